// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Digit width, FSM states and the active-low digit select builder.
package display_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_e;

    // All ones except a single zero at position idx.
    function automatic logic [MAX_DIGITS-1:0] sel_n(input logic [4:0] idx);
        logic [MAX_DIGITS-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/display_phase_timer.sv
// Loadable down-counter timing the BLANK and SHOW phases.
// done_o is high while the count sits at zero.
module display_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Clear wins over load; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-aligned double buffering.
// Values are staged via valid/ready and committed only at frame edges.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] in_diff,
    input  logic [NUM_DIGITS-1:0]         in_sinal,
    output logic [DIGIT_W-1:0]            dec_diff,
    output logic                          dec_sinal,
    output logic [NUM_DIGITS-1:0]         digit_en_n,
    output logic                          frame_done
);

    localparam int MAX_PH = (SHOW_CYCLES > BLANK_CYCLES) ?
                            SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W  = $clog2(MAX_PH + 1);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DW     = NUM_DIGITS * DIGIT_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SHOW_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DW-1:0]           act_diff_q, act_diff_d;
    logic [NUM_DIGITS-1:0]   act_sinal_q, act_sinal_d;
    logic [DW-1:0]           stg_diff_q, stg_diff_d;
    logic [NUM_DIGITS-1:0]   stg_sinal_q, stg_sinal_d;
    logic                    pend_q, pend_d;
    logic [DIGIT_W-1:0]      dec_diff_q, dec_diff_d;
    logic                    dec_sinal_q, dec_sinal_d;
    logic [NUM_DIGITS-1:0]   dig_en_n_q, dig_en_n_d;
    logic                    frame_done_q, frame_done_d;
    logic                    in_ready_q;

    logic                    accept;
    logic                    commit;
    logic                    tmr_clr;
    logic                    tmr_load;
    logic [CNT_W-1:0]        tmr_val;
    logic                    tmr_done;
    logic [MAX_DIGITS-1:0]   sel_full;

    display_phase_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Next-state, buffer commit and next output values.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        accept       = in_valid && !pend_q;

        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (enable) state_d = BLANK;
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (tmr_done) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (tmr_done) begin
                    state_d = BLANK;
                    if (idx_q == LAST_IDX) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        commit      = pend_q && ((state_q == IDLE) || frame_done_d);
        act_diff_d  = commit ? stg_diff_q  : act_diff_q;
        act_sinal_d = commit ? stg_sinal_q : act_sinal_q;
        stg_diff_d  = accept ? in_diff     : stg_diff_q;
        stg_sinal_d = accept ? in_sinal    : stg_sinal_q;
        pend_d      = commit ? 1'b0 : (accept ? 1'b1 : pend_q);

        tmr_clr  = (state_d == IDLE);
        tmr_load = (state_d != state_q) && (state_d != IDLE);
        tmr_val  = (state_d == BLANK) ? BLANK_LD : SHOW_LD;

        sel_full   = sel_n(5'(idx_d));
        dig_en_n_d = (state_d == SHOW) ? sel_full[NUM_DIGITS-1:0] : '1;

        if (state_d == IDLE) begin
            dec_diff_d  = '0;
            dec_sinal_d = 1'b0;
        end else begin
            dec_diff_d  = act_diff_d[int'(idx_d)*DIGIT_W +: DIGIT_W];
            dec_sinal_d = act_sinal_d[idx_d];
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            act_diff_q   <= '0;
            act_sinal_q  <= '0;
            stg_diff_q   <= '0;
            stg_sinal_q  <= '0;
            pend_q       <= 1'b0;
            dec_diff_q   <= '0;
            dec_sinal_q  <= 1'b0;
            dig_en_n_q   <= '1;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            act_diff_q   <= act_diff_d;
            act_sinal_q  <= act_sinal_d;
            stg_diff_q   <= stg_diff_d;
            stg_sinal_q  <= stg_sinal_d;
            pend_q       <= pend_d;
            dec_diff_q   <= dec_diff_d;
            dec_sinal_q  <= dec_sinal_d;
            dig_en_n_q   <= dig_en_n_d;
            frame_done_q <= frame_done_d;
            in_ready_q   <= !pend_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign dec_diff   = dec_diff_q;
    assign dec_sinal  = dec_sinal_q;
    assign digit_en_n = dig_en_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with 2 digits, SHOW=4, BLANK=2.
// Table-driven first frames, then hand-written corner sequences.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_diff;
    logic [1:0] in_sinal;
    logic [3:0] dec_diff;
    logic       dec_sinal;
    logic [1:0] digit_en_n;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic       vld;
        logic [7:0] diff;
        logic [1:0] sin;
        logic [1:0] x_en_n;
        logic [3:0] x_diff;
        logic       x_sin;
        logic       x_fd;
        logic       x_rdy;
    } vec_t;

    vec_t vecs[17];

    display_scan_ctrl #(
        .NUM_DIGITS   (2),
        .SHOW_CYCLES  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_diff    (in_diff),
        .in_sinal   (in_sinal),
        .dec_diff   (dec_diff),
        .dec_sinal  (dec_sinal),
        .digit_en_n (digit_en_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name,
                       input logic [1:0] x_en_n,
                       input logic [3:0] x_diff,
                       input logic       x_sin,
                       input logic       x_fd,
                       input logic       x_rdy);
        checks++;
        if (digit_en_n !== x_en_n || dec_diff !== x_diff ||
            dec_sinal !== x_sin || frame_done !== x_fd ||
            in_ready !== x_rdy) begin
            errors++;
            $display("FAIL %s: got en_n=%b diff=%h sin=%b fd=%b rdy=%b exp en_n=%b diff=%h sin=%b fd=%b rdy=%b",
                     name, digit_en_n, dec_diff, dec_sinal, frame_done,
                     in_ready, x_en_n, x_diff, x_sin, x_fd, x_rdy);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 8'h53, 2'b10, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 2'b00, 2'b11, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b11, 4'h3, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b11, 4'h3, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b10, 4'h3, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b10, 4'h3, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b10, 4'h3, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b10, 4'h3, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b11, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b11, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b01, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b01, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b01, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b01, 4'h5, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b11, 4'h3, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b11, 4'h3, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 8'h00, 2'b00, 2'b10, 4'h3, 1'b0, 1'b0, 1'b1};

        rst_n    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_diff  = 8'h00;
        in_sinal = 2'b00;
        run(2);
        chk("reset", 2'b11, 4'h0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Load in IDLE, then scan one full frame plus a bit.
        for (int i = 0; i < 17; i++) begin
            enable   = vecs[i].en;
            in_valid = vecs[i].vld;
            in_diff  = vecs[i].diff;
            in_sinal = vecs[i].sin;
            step();
            chk($sformatf("vec%0d", i), vecs[i].x_en_n, vecs[i].x_diff,
                vecs[i].x_sin, vecs[i].x_fd, vecs[i].x_rdy);
        end

        // Mid-frame offer: staged, not shown until the boundary.
        in_valid = 1'b1;
        in_diff  = 8'h21;
        in_sinal = 2'b00;
        step();
        chk("mid_accept", 2'b10, 4'h3, 1'b0, 1'b0, 1'b0);

        // Second offer held while pending.
        in_diff  = 8'h76;
        in_sinal = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: got rdy=%b fd=%b exp rdy=0 fd=0",
                         i, in_ready, frame_done);
            end
        end
        step();
        chk("boundary1", 2'b11, 4'h1, 1'b0, 1'b1, 1'b1);
        step();
        chk("held_accept", 2'b11, 4'h1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        step();
        chk("new_d0", 2'b10, 4'h1, 1'b0, 1'b0, 1'b0);
        run(3);
        step();
        chk("new_d1_blank", 2'b11, 4'h2, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("new_d1_show", 2'b01, 4'h2, 1'b0, 1'b0, 1'b0);
        run(3);
        step();
        chk("boundary2", 2'b11, 4'h6, 1'b1, 1'b1, 1'b1);

        // Drop enable during digit1 SHOW.
        step();
        run(4);
        step();
        step();
        step();
        chk("d1_show", 2'b01, 4'h7, 1'b1, 1'b0, 1'b1);
        enable = 1'b0;
        step();
        chk("disable", 2'b11, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("idle%0d", i), 2'b11, 4'h0, 1'b0, 1'b0, 1'b1);
        end
        enable = 1'b1;
        step();
        chk("restart_blank", 2'b11, 4'h6, 1'b1, 1'b0, 1'b1);
        step();
        step();
        chk("restart_show", 2'b10, 4'h6, 1'b1, 1'b0, 1'b1);

        // Reset pulse mid-SHOW with a pending offer.
        in_valid = 1'b1;
        in_diff  = 8'h99;
        in_sinal = 2'b11;
        step();
        chk("pend_pre_rst", 2'b10, 4'h6, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        chk("mid_reset", 2'b11, 4'h0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();
        chk("post_rst_blank", 2'b11, 4'h0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        chk("post_rst_show", 2'b10, 4'h0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexes NUM_DIGITS seven-segment digits over one shared `display` decoder. Each digit has a signed-magnitude value: 4-bit `diff` plus the `sinal` bit. The block double-buffers incoming values through a valid/ready handshake and commits them only at frame boundaries, so a frame never mixes old and new values. It scans the digits with a blanking gap between them to suppress ghosting, and drives the shared decoder inputs and the active-low digit enables.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (≥2)
SHOW_CYCLES, 1000, clock cycles each digit is lit (≥1)
BLANK_CYCLES, 8, clock cycles all digits are dark before each digit (≥1)
CNT_W, $clog2(max(SHOW_CYCLES,BLANK_CYCLES)+1), phase counter width (derived, do not override)

Ports:
clk  in  1  system clock, single domain
rst_n  in  1  synchronous active-low reset
enable  in  1  scanning enable; low = all digits dark
in_valid  in  1  new frame values offered
in_ready  out  1  staging buffer free; transfer when in_valid & in_ready
in_diff  in  4*NUM_DIGITS  digit k magnitude in bits [4k+3:4k]
in_sinal  in  NUM_DIGITS  digit k sign in bit k
dec_diff  out  4  to shared decoder `diff`
dec_sinal  out  1  to shared decoder `sinal`
digit_en_n  out  NUM_DIGITS  active-low digit select; at most one bit low
frame_done  out  1  one-cycle pulse after the last digit's SHOW phase

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, idx=0, counter=0.
  - Active and staging registers = 0; pending=0.
  - Outputs: dec_diff=0, dec_sinal=0, digit_en_n=all 1, in_ready=1, frame_done=0.
  - Reset mid-frame aborts the scan immediately.
- All outputs are registered.
- in_ready = !pending.
- Accept: when in_valid & in_ready, latch in_diff/in_sinal into staging and set pending=1 on the next edge. in_valid with in_ready=0 is ignored; the producer holds it.
- States:
  - IDLE: digit_en_n=all 1, counter=0, idx=0.
    - If pending, copy staging to active and clear pending on the same edge.
    - If enable=1, go to BLANK.
  - BLANK: digit_en_n=all 1; dec_diff/dec_sinal = active[idx] (decoder setup).
    - Lasts BLANK_CYCLES cycles, then go to SHOW with counter cleared.
  - SHOW: digit_en_n[idx]=0, others 1; dec outputs = active[idx].
    - Lasts SHOW_CYCLES cycles, then go to BLANK.
    - idx<NUM_DIGITS-1: idx increments.
    - idx=NUM_DIGITS-1: idx wraps to 0, frame_done=1 for exactly the next cycle, and if pending, staging is copied to active and pending clears on that same edge.
- Frame period = NUM_DIGITS*(SHOW_CYCLES+BLANK_CYCLES) cycles.
- Latency: a value accepted during frame F appears from the first digit of frame F+1. A value accepted in IDLE is active one cycle later.
- enable deasserted in BLANK or SHOW: next edge goes to IDLE, with digits dark, idx=0 and counter=0. pending and staging are preserved; no frame_done is emitted.
- Simultaneous commit and new in_valid: in_ready is 0 during the commit cycle, so the offer is not accepted. in_ready=1 on the following cycle.
- The active buffer never changes outside a frame boundary or IDLE.
- Counter compares use the parameters directly; no wrap beyond max(SHOW_CYCLES,BLANK_CYCLES).

Decomposition:
- Package display_pkg:
  - state enum {IDLE, BLANK, SHOW};
  - DIGIT_W=4;
  - helper function for active-low one-hot select generation.
- Sub-module display_phase_timer: loadable down-counter with `done` output, reused for both the BLANK and SHOW phases.
- The existing `display` decoder is instantiated by the parent, not inside this block.

Test Plan (NUM_DIGITS=2, SHOW_CYCLES=4, BLANK_CYCLES=2):
1. Reset then enable=1 with no data. Required: 2 cycles all dark, then digit_en_n=2'b10 for 4 cycles with dec_diff=0/dec_sinal=0, 2 dark cycles, then 2'b01 for 4 cycles. frame_done pulses once at cycle 12 and repeats every 12 cycles.
2. In IDLE, in_valid=1 with in_diff=8'h53, in_sinal=2'b10. Required: in_ready 1→0→1. After enable, digit0 shows dec_diff=3/dec_sinal=0 and digit1 shows dec_diff=5/dec_sinal=1.
3. Mid-frame (during digit0 SHOW), send in_diff=8'h21. Required: the current frame keeps the old values, in_ready stays 0 until the boundary, and the new values appear at the next frame's digit0.
4. Second in_valid while pending=1. Required: not accepted (in_ready=0). The held offer is accepted the cycle after the boundary commit.
5. Drop enable during digit1 SHOW. Required: next cycle digit_en_n=2'b11, no frame_done. Re-enable restarts at BLANK of digit0.
6. Assert rst_n=0 for one cycle mid-SHOW. Required: next cycle all outputs at reset values, pending=0, and active values cleared to 0.
